dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Memory-side responder for the pipeline's data-memory port: accepts one load/store
//  request at a time over a req/ready handshake and answers after a programmable
//  number of wait cycles, like a slow external SRAM. Word-addressed 32-bit storage.
//  Sits behind the MA stage. Lets the team add stall logic against a memory that is
//  not zero-latency.
// PARAMETERS
//  ADDR_W   8  word-address bits; depth = 2**ADDR_W words (byte range 0 .. 4*2**ADDR_W-1)
//  LATENCY  2  wait cycles between accept and access (0..15)
// PORTS
//  clk     in   1   clock, all state updates on rising edge
//  reset   in   1   synchronous, active-low reset
//  req     in   1   request valid; hold with addr/we/wdata until accepted
//  we      in   1   1 = store, 0 = load
//  addr    in   32  byte address; must be word-aligned
//  wdata   in   32  store data
//  ready   out  1   responder idle; request accepted on an edge where req & ready
//  done    out  1   one-cycle pulse: access finished (load or store)
//  rdata   out  32  load result, valid while done=1; held until the next load completes
//  err     out  1   one-cycle pulse together with done: misaligned or out-of-range address
// BEHAVIOUR
//  - reset: while reset=0 at an edge: state=IDLE, ready=0, done=0, err=0, rdata=0,
//    wait counter=0. Memory array is NOT cleared. ready rises on the first edge with
//    reset=1.
//  - FSM states:
//    - IDLE: ready=1. On req=1, latch addr/we/wdata, load cnt=LATENCY, go to BUSY,
//      ready=0.
//    - BUSY: ready=0, req ignored. If cnt!=0, cnt--. If cnt==0, perform access at
//      this edge, pulse done, return to IDLE (ready=1 in the same cycle as done).
//  - Latency: request accepted on edge n; done visible after edge n+1+LATENCY.
//    Earliest next accept is edge n+2+LATENCY.
//  - Address check on the latched addr:
//    - misaligned: addr[1:0]!=0
//    - out of range: addr[31:ADDR_W+2]!=0
//    - Either condition gives done=1 and err=1, no store, rdata forced to 0.
//  - Store: mem[addr[ADDR_W+1:2]] <= wdata at the done edge; rdata unchanged.
//  - Load: rdata <= mem[addr[ADDR_W+1:2]] at the done edge; the value reflects all
//    earlier completed stores.
//  - Inputs changing while BUSY have no effect (latched copy is used).
//  - reset=0 while BUSY aborts: a pending store is not committed and no done pulse
//    is generated.
//  - done and err are never high outside the single completion cycle. err never
//    rises without done.
// TESTING
//  - Reset: hold reset=0 for 3 edges with req=1 -> ready=0, done=0, rdata=0;
//    first edge with reset=1 -> ready=1.
//  - Store/load, LATENCY=2:
//    - store addr=0x10, wdata=0xDEADBEEF accepted at edge n -> done at n+3, err=0;
//    - then load 0x10 -> rdata=0xDEADBEEF with done at accept+3.
//  - LATENCY=0: back-to-back loads of 0x0 and 0x4 (preloaded 0x11, 0x22) ->
//    done every 2 cycles, rdata=0x11 then 0x22.
//  - Errors:
//    - load addr=0x6 -> done=1, err=1, rdata=0;
//    - store addr=0x400 (ADDR_W=8) -> err=1, and a later load of 0x0 shows an
//      unchanged word.
//  - Busy protection: change addr/wdata/we and keep req=1 during BUSY ->
//    the original latched request completes; the new request is accepted only after
//    done.
//  - Abort: store 0x20=0xCAFEF00D, drop reset=0 one edge after accept ->
//    no done; after reset, load 0x20 returns the prior contents.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: slow data-memory model that sits behind the MA stage.
// It takes one load/store at a time over req/ready and completes it LATENCY
// wait cycles later. Storage is word-addressed, 2**ADDR_W x 32 bits.
//
// Ports:
//   clk    in   1   clock, rising edge
//   reset  in   1   synchronous active-low reset
//   req    in   1   request valid, held with we/addr/wdata until accepted
//   we     in   1   1 = store, 0 = load
//   addr   in   32  byte address, must be word-aligned and in range
//   wdata  in   32  store data
//   ready  out  1   idle; request taken on an edge with req & ready
//   done   out  1   one-cycle completion pulse
//   rdata  out  32  load result, held until the next completed load
//   err    out  1   one-cycle pulse with done on a misaligned/out-of-range address
module dmem_responder #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        ready_q, ready_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    logic [31:0]       mem_q [Depth];
    logic [ADDR_W-1:0] idx;
    logic              addr_bad;
    logic              access;
    logic              mem_we;

    // All checks and the access use the copy latched at accept time.
    assign idx      = addr_q[ADDR_W+1:2];
    assign addr_bad = (addr_q[1:0] != 2'b00) || ((addr_q >> (ADDR_W + 2)) != 32'd0);
    assign access   = (state_q == StBusy) && (cnt_q == 4'd0);
    // Gated by reset so an abort in the completion cycle does not commit the store.
    assign mem_we   = reset && access && we_q && !addr_bad;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        ready_d = ready_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            StIdle: begin
                ready_d = 1'b1;
                // ready_q gates acceptance so the first edge out of reset only raises ready.
                if (ready_q && req) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    we_d    = we;
                    cnt_d   = 4'(LATENCY);
                    state_d = StBusy;
                    ready_d = 1'b0;
                end
            end
            StBusy: begin
                ready_d = 1'b0;
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = StIdle;
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                    err_d   = addr_bad;
                    if (addr_bad) begin
                        rdata_d = 32'd0;
                    end else if (!we_q) begin
                        rdata_d = mem_q[idx];
                    end
                end
            end
            default: begin
                state_d = StIdle;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx] <= wdata_q;
        end
    end

    assign ready = ready_q;
    assign done  = done_q;
    assign err   = err_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (LATENCY=2 and LATENCY=0) share the
// stimulus bus; sel steers req to one of them. A word-array model per instance
// predicts rdata/err from the address rules and accept-to-done latency.
module tb_dmem_responder;

    logic        clk;
    logic        reset;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        sel;  // 1 = LATENCY-2 instance, 0 = LATENCY-0 instance

    logic        ready2, done2, err2;
    logic [31:0] rdata2;
    logic        ready0, done0, err0;
    logic [31:0] rdata0;
    logic        req2, req0;

    logic        rdy, dn, er;
    logic [31:0] rd;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [31:0] mem2 [256];
    logic [31:0] mem0 [256];
    logic [31:0] rd2_m, rd0_m;
    int          last_done_cyc;

    assign req2 = req & sel;
    assign req0 = req & ~sel;
    assign rdy  = sel ? ready2 : ready0;
    assign dn   = sel ? done2  : done0;
    assign er   = sel ? err2   : err0;
    assign rd   = sel ? rdata2 : rdata0;

    dmem_responder #(.ADDR_W(8), .LATENCY(2)) u_dut2 (
        .clk   (clk),
        .reset (reset),
        .req   (req2),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .ready (ready2),
        .done  (done2),
        .rdata (rdata2),
        .err   (err2)
    );

    dmem_responder #(.ADDR_W(8), .LATENCY(0)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .req   (req0),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .ready (ready0),
        .done  (done0),
        .rdata (rdata0),
        .err   (err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic addr_is_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'd1024);
    endfunction

    // Model update for one completed access on the selected instance.
    task automatic model_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                                output logic exp_err, output logic [31:0] exp_rd);
        exp_err = addr_is_bad(a);
        if (sel) begin
            if (exp_err) rd2_m = 32'd0;
            else if (w) mem2[a / 4] = d;
            else rd2_m = mem2[a / 4];
            exp_rd = rd2_m;
        end else begin
            if (exp_err) rd0_m = 32'd0;
            else if (w) mem0[a / 4] = d;
            else rd0_m = mem0[a / 4];
            exp_rd = rd0_m;
        end
    endtask

    // Wait (bounded) for done after an accept edge; returns edges counted.
    task automatic wait_done(output int k);
        k = 0;
        while (!dn && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
    endtask

    // One full transaction; inputs are scrambled while busy to show they are ignored.
    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d);
        int          k;
        int          lat;
        logic        exp_err;
        logic [31:0] exp_rd;
        lat   = sel ? 2 : 0;
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        k = 0;
        while (!rdy && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("ready_before_accept", 32'(rdy), 32'd1);
        @(posedge clk); #1;
        req   = 1'b0;
        we    = ~w;
        addr  = $urandom;
        wdata = $urandom;
        chk("ready_low_busy", 32'(rdy), 32'd0);
        chk("done_low_after_accept", 32'(dn), 32'd0);
        wait_done(k);
        model_access(w, a, d, exp_err, exp_rd);
        chk("latency_edges", 32'(k), 32'(lat + 1));
        chk("done_pulse", 32'(dn), 32'd1);
        chk("err_flag", 32'(er), 32'(exp_err));
        chk("rdata", rd, exp_rd);
        chk("ready_with_done", 32'(rdy), 32'd1);
        last_done_cyc = cyc;
    endtask

    initial begin
        int          k;
        int          c1;
        int          n_done;
        logic [31:0] a;
        logic [31:0] prior;
        logic        exp_err;
        logic [31:0] exp_rd;

        reset = 1'b0;
        req   = 1'b1;
        we    = 1'b0;
        addr  = 32'd0;
        wdata = 32'd0;
        sel   = 1'b1;
        rd2_m = 32'd0;
        rd0_m = 32'd0;

        // Reset held for three edges with req asserted.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready2", 32'(ready2), 32'd0);
        chk("rst_done2", 32'(done2), 32'd0);
        chk("rst_err2", 32'(err2), 32'd0);
        chk("rst_rdata2", rdata2, 32'd0);
        chk("rst_ready0", 32'(ready0), 32'd0);
        req   = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("first_edge_ready2", 32'(ready2), 32'd1);
        chk("first_edge_ready0", 32'(ready0), 32'd1);

        // Preload every word of the LATENCY-2 instance.
        for (int i = 0; i < 256; i++) txn(1'b1, 32'(i * 4), $urandom);

        // Directed store/load.
        txn(1'b1, 32'h10, 32'hDEAD_BEEF);
        txn(1'b0, 32'h10, 32'h0);
        chk("load_deadbeef", rd, 32'hDEAD_BEEF);

        // Error cases.
        txn(1'b0, 32'h6, 32'h0);
        prior = mem2[0];
        txn(1'b1, 32'h400, 32'h5555_AAAA);
        txn(1'b0, 32'h0, 32'h0);
        chk("word0_unchanged", rd, prior);

        // Busy protection: a different request held during BUSY waits for done.
        req   = 1'b1;
        we    = 1'b1;
        addr  = 32'h40;
        wdata = 32'h1234_5678;
        @(posedge clk); #1;
        chk("bp_accept", 32'(rdy), 32'd0);
        we    = 1'b0;
        addr  = 32'h44;
        wdata = 32'hFFFF_0000;
        wait_done(k);
        model_access(1'b1, 32'h40, 32'h1234_5678, exp_err, exp_rd);
        chk("bp_first_latency", 32'(k), 32'd3);
        chk("bp_first_err", 32'(er), 32'd0);
        @(posedge clk); #1;
        chk("bp_second_accept", 32'(rdy), 32'd0);
        chk("bp_done_cleared", 32'(dn), 32'd0);
        req = 1'b0;
        wait_done(k);
        model_access(1'b0, 32'h44, 32'h0, exp_err, exp_rd);
        chk("bp_second_latency", 32'(k), 32'd3);
        chk("bp_second_rdata", rd, exp_rd);
        txn(1'b0, 32'h40, 32'h0);
        chk("bp_store_kept", rd, 32'h1234_5678);

        // Abort: reset one edge after accepting a store.
        prior = mem2[8];
        req   = 1'b1;
        we    = 1'b1;
        addr  = 32'h20;
        wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        chk("abort_accept", 32'(rdy), 32'd0);
        req   = 1'b0;
        reset = 1'b0;
        n_done = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (done2) n_done++;
        end
        reset = 1'b1;
        rd2_m = 32'd0;
        rd0_m = 32'd0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done2) n_done++;
        end
        chk("abort_no_done", 32'(n_done), 32'd0);
        chk("abort_ready_back", 32'(ready2), 32'd1);
        chk("abort_rdata_reset", rdata2, 32'd0);
        txn(1'b0, 32'h20, 32'h0);
        chk("abort_prior_kept", rd, prior);

        // Randomized traffic against the model.
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 9))
                0:       a = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
                1:       a = ($urandom & 32'hFFFF_FFFC) | 32'h0000_0400;
                default: a = 32'($urandom_range(0, 255)) << 2;
            endcase
            txn(1'($urandom_range(0, 1)), a, $urandom);
        end

        // LATENCY=0 instance: back-to-back loads complete every two cycles.
        sel = 1'b0;
        txn(1'b1, 32'h0, 32'h11);
        txn(1'b1, 32'h4, 32'h22);
        txn(1'b0, 32'h0, 32'h0);
        chk("l0_load0", rd, 32'h11);
        c1 = last_done_cyc;
        txn(1'b0, 32'h4, 32'h0);
        chk("l0_load4", rd, 32'h22);
        chk("l0_done_spacing", 32'(last_done_cyc - c1), 32'd2);
        txn(1'b0, 32'h6, 32'h0);

        @(posedge clk); #1;
        chk("final_done_low", 32'(done0), 32'd0);
        chk("final_err_low", 32'(err0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
